player_laser: RTL and testbench

Player laser controller: converts the debounced shoot button into a single on-screen laser that launches from the player's gun position and travels upward until it hits an enemy, reaches the top border or is cancelled. Sits directly downstream of the player ship FSM: consumes its `gun_pos_o`, `alive_o` and freeze status, and feeds the enemy-collision logic and the VGA renderer. Only one player laser exists at a time.

---
 rtl/player_pkg.sv | 27 ++
 rtl/tick_gen.sv | 29 ++
 rtl/player_laser.sv | 158 +++++++++++++++
 tb/tb_player_laser.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared player definitions: laser state encoding, screen geometry and borders.
// Used by the player ship, the player laser and the renderer.
package player_pkg;

  typedef enum logic [2:0] {
    LASER_IDLE     = 3'b001,
    LASER_FLYING   = 3'b010,
    LASER_COOLDOWN = 3'b100
  } laser_state_e;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam logic [9:0] BORDER_LEFT  = 10'd8;
  localparam logic [9:0] BORDER_RIGHT = 10'd631;
  localparam logic [9:0] BORDER_TOP   = 10'd8;

  // True when one more upward step keeps y at or below the top border.
  function automatic logic can_step(
    input logic [9:0] y,
    input logic [9:0] top,
    input logic [3:0] step
  );
    return {1'b0, y} >= ({1'b0, top} + {7'd0, step});
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Divider producing a one-cycle tick every div_p enabled cycles.
// clr has priority over en and zeroes the count.
module tick_gen #(
  parameter logic [19:0] div_p = 20'd250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [19:0] LAST = div_p - 20'd1;

  logic [19:0] count;

  assign tick = en && !clr && (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else if (en) begin
      count <= count + 20'd1;
    end
  end

endmodule

// File: rtl/player_laser.sv
// Player laser: launches on a fire edge, climbs to the top border, retires.
// Optional post-retire cooldown is built when PLAYER_LASER_COOLDOWN_EN is defined.
module player_laser
  import player_pkg::*;
#(
  parameter logic [11:0] color_p      = 12'b1111_1111_0000,
  parameter logic [9:0]  spawn_y_p    = 10'd440,
  parameter logic [9:0]  top_border_p = 10'd8,
  parameter logic [3:0]  step_p       = 4'd4,
  parameter logic [19:0] div_p        = 20'd250000
`ifdef PLAYER_LASER_COOLDOWN_EN
  ,
  parameter logic [19:0] cooldown_p   = 20'd500000
`endif
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       fire_i,
  input  logic [9:0] gun_pos_i,
  input  logic       alive_i,
  input  logic       freeze_i,
  input  logic       hit_enemy_i,
  output logic       active_o,
  output logic       fired_o,
  output logic [9:0] laser_x_o,
  output logic [9:0] laser_y_o,
  output logic [3:0] laser_red_o,
  output logic [3:0] laser_green_o,
  output logic [3:0] laser_blue_o,
  output logic [2:0] state_o
);

  localparam logic [2:0] ST_IDLE   = LASER_IDLE;
  localparam logic [2:0] ST_FLYING = LASER_FLYING;
`ifdef PLAYER_LASER_COOLDOWN_EN
  localparam logic [2:0] ST_COOL   = LASER_COOLDOWN;
  localparam logic [2:0] ST_RETIRE = ST_COOL;
`else
  localparam logic [2:0] ST_RETIRE = ST_IDLE;
`endif

  logic [2:0] state;
  logic [2:0] state_n;
  logic [9:0] x_q;
  logic [9:0] x_n;
  logic [9:0] y_q;
  logic [9:0] y_n;
  logic       fire_q;
  logic       fired_q;
  logic       fired_n;
  logic       active_q;

  logic launch;
  logic in_flight;
  logic step_tick;
  logic retire;

  assign launch    = fire_i & ~fire_q;
  assign in_flight = (state == ST_FLYING);

  tick_gen #(
    .div_p(div_p)
  ) u_step (
    .clk  (clk_i),
    .rst_n(reset_n_i),
    .en   (in_flight & alive_i & ~freeze_i),
    .clr  (~in_flight),
    .tick (step_tick)
  );

`ifdef PLAYER_LASER_COOLDOWN_EN
  logic in_cool;
  logic cool_tick;

  assign in_cool = (state == ST_COOL);

  tick_gen #(
    .div_p(cooldown_p)
  ) u_cool (
    .clk  (clk_i),
    .rst_n(reset_n_i),
    .en   (in_cool & alive_i & ~freeze_i),
    .clr  (~in_cool),
    .tick (cool_tick)
  );
`endif

  // Cancel beats hit beats a border step; the border compare precedes the subtract.
  assign retire = !alive_i
    || (!freeze_i && hit_enemy_i)
    || (!freeze_i && step_tick
        && !can_step(y_q, top_border_p, step_p));

  always_comb begin
    state_n = state;
    x_n     = x_q;
    y_n     = y_q;
    fired_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (launch && alive_i && !freeze_i) begin
          state_n = ST_FLYING;
          x_n     = gun_pos_i;
          y_n     = spawn_y_p;
          fired_n = 1'b1;
        end
      end
      ST_FLYING: begin
        if (retire) begin
          state_n = ST_RETIRE;
          y_n     = spawn_y_p;
        end else if (!freeze_i && step_tick) begin
          y_n = y_q - {6'd0, step_p};
        end
      end
`ifdef PLAYER_LASER_COOLDOWN_EN
      ST_COOL: begin
        if (!alive_i || cool_tick) begin
          state_n = ST_IDLE;
        end
      end
`endif
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state    <= ST_IDLE;
      x_q      <= '0;
      y_q      <= spawn_y_p;
      fire_q   <= 1'b0;
      fired_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state    <= state_n;
      x_q      <= x_n;
      y_q      <= y_n;
      fired_q  <= fired_n;
      active_q <= (state_n == ST_FLYING);
      if (!freeze_i) begin
        fire_q <= fire_i;
      end
    end
  end

  assign active_o      = active_q;
  assign fired_o       = fired_q;
  assign laser_x_o     = x_q;
  assign laser_y_o     = y_q;
  assign state_o       = state;
  assign laser_red_o   = color_p[11:8];
  assign laser_green_o = color_p[7:4];
  assign laser_blue_o  = color_p[3:0];

endmodule

// File: tb/tb_player_laser.sv
// Self-checking bench for player_laser: directed scenarios plus random stimulus
// compared every cycle against a behavioural model of the laser rules.
module tb_player_laser;

  localparam logic [9:0]  SPAWN = 10'd40;
  localparam logic [9:0]  TOP   = 10'd8;
  localparam logic [3:0]  STEP  = 4'd4;
  localparam logic [19:0] DIV   = 20'd2;
`ifdef PLAYER_LASER_COOLDOWN_EN
  localparam int CD = 3;
`else
  localparam int CD = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       fire = 1'b0;
  logic [9:0] gun = '0;
  logic       alive = 1'b1;
  logic       freeze = 1'b0;
  logic       hit = 1'b0;

  logic       active;
  logic       fired;
  logic [9:0] lx;
  logic [9:0] ly;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic [2:0] state;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  player_laser #(
    .color_p     (12'b1111_1111_0000),
    .spawn_y_p   (SPAWN),
    .top_border_p(TOP),
    .step_p      (STEP),
    .div_p       (DIV)
`ifdef PLAYER_LASER_COOLDOWN_EN
    ,
    .cooldown_p  (20'd3)
`endif
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .fire_i       (fire),
    .gun_pos_i    (gun),
    .alive_i      (alive),
    .freeze_i     (freeze),
    .hit_enemy_i  (hit),
    .active_o     (active),
    .fired_o      (fired),
    .laser_x_o    (lx),
    .laser_y_o    (ly),
    .laser_red_o  (red),
    .laser_green_o(green),
    .laser_blue_o (blue),
    .state_o      (state)
  );

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: laser age counts unfrozen flying cycles; a step is
  // due on every DIV-th such cycle. Cooldown is a remaining-cycle count.
  int m_active = 0;
  int m_fired = 0;
  int m_x = 0;
  int m_y = int'(SPAWN);
  int m_fprev = 0;
  int m_age = 0;
  int m_cd = 0;
  int m_launch;

  task automatic m_retire();
    m_active = 0;
    m_y = int'(SPAWN);
    m_cd = CD;
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      m_active = 0;
      m_fired = 0;
      m_x = 0;
      m_y = int'(SPAWN);
      m_fprev = 0;
      m_age = 0;
      m_cd = 0;
    end else begin
      m_launch = (fire && !m_fprev) ? 1 : 0;
      m_fired = 0;
      if (m_active != 0) begin
        if (!alive) begin
          m_retire();
        end else if (!freeze) begin
          if (hit) begin
            m_retire();
          end else begin
            if (m_age % int'(DIV) == int'(DIV) - 1) begin
              if (m_y - int'(STEP) >= int'(TOP)) m_y = m_y - int'(STEP);
              else m_retire();
            end
            m_age++;
          end
        end
      end else if (m_cd > 0) begin
        if (!alive) m_cd = 0;
        else if (!freeze) m_cd--;
      end else if (m_launch != 0 && alive && !freeze) begin
        m_active = 1;
        m_fired = 1;
        m_x = int'(gun);
        m_y = int'(SPAWN);
        m_age = 0;
      end
      if (!freeze) m_fprev = fire ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_active", int'(active), m_active);
      chk("m_fired", int'(fired), m_fired);
      chk("m_x", int'(lx), m_x);
      chk("m_y", int'(ly), m_y);
      chk("m_state", int'(state),
          (m_active != 0) ? 2 : ((m_cd > 0) ? 4 : 1));
      chk("colour", int'({red, green, blue}), 12'hff0);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  int min_y;
  bit done;

  initial begin
    reset_n = 1'b0;
    repeat (3) cyc();
    check_en = 1'b1;
    reset_n = 1'b1;
    cyc();
    chk("rst_active", int'(active), 0);
    chk("rst_fired", int'(fired), 0);
    chk("rst_x", int'(lx), 0);
    chk("rst_y", int'(ly), 40);
    chk("rst_state", int'(state), 1);

    // Launch, then climb to the border with fire held.
    gun = 10'd300;
    fire = 1'b1;
    cyc();
    chk("launch_active", int'(active), 1);
    chk("launch_fired", int'(fired), 1);
    chk("launch_x", int'(lx), 300);
    chk("launch_y", int'(ly), 40);
    chk("launch_state", int'(state), 2);
    cyc();
    chk("pulse_once", int'(fired), 0);
    chk("y_before_step", int'(ly), 40);
    cyc();
    chk("first_step_y", int'(ly), 36);
    min_y = 36;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      cyc();
      if (!active) done = 1'b1;
      else if (int'(ly) < min_y) min_y = int'(ly);
    end
    chk("top_timeout", int'(done), 1);
    chk("top_min_y", min_y, 8);
    chk("retire_y", int'(ly), 40);
    for (int i = 0; i < CD + 4; i++) begin
      cyc();
      chk("held_no_refire", int'(active), 0);
    end

    // Release and press again with a new gun position.
    fire = 1'b0;
    cyc();
    gun = 10'd123;
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    chk("relaunch_active", int'(active), 1);
    chk("relaunch_x", int'(lx), 123);

    // Hit arriving on the same cycle as a step tick.
    cyc();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    chk("hit_active", int'(active), 0);
    chk("hit_y", int'(ly), 40);
`ifdef PLAYER_LASER_COOLDOWN_EN
    chk("hit_cool_state", int'(state), 4);
`else
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    chk("launch_after_fall", int'(active), 1);
    alive = 1'b0;
    cyc();
    alive = 1'b1;
`endif
    repeat (CD + 2) cyc();

    // Freeze mid-flight, then cancel while frozen.
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    chk("frz_launch", int'(active), 1);
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("frz_y", int'(ly), 40);
      chk("frz_active", int'(active), 1);
    end
    freeze = 1'b0;
    cyc();
    cyc();
    chk("frz_resume_y", int'(ly), 36);
    freeze = 1'b1;
    alive = 1'b0;
    cyc();
    chk("frz_cancel", int'(active), 0);
    freeze = 1'b0;
    alive = 1'b1;
    repeat (CD + 2) cyc();

`ifdef PLAYER_LASER_COOLDOWN_EN
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    chk("cd_launch", int'(active), 1);
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    chk("cd_enter", int'(state), 4);
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    chk("cd_drop", int'(active), 0);
    cyc();
    cyc();
    chk("cd_idle", int'(state), 1);
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    chk("cd_after", int'(active), 1);
    repeat (40) cyc();
`endif

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if ($urandom_range(3) == 0) fire = ~fire;
      alive   = ($urandom_range(59) != 0);
      freeze  = ($urandom_range(11) == 0);
      hit     = ($urandom_range(24) == 0);
      gun     = 10'($urandom_range(639));
      reset_n = ($urandom_range(299) != 0);
    end
    reset_n = 1'b1;
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
